// File: rtl/nes_dma_pkg.sv
// Shared types and default addresses for the NES sprite (OAM) DMA engine.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    RD_ADDR,
    RD_DATA,
    WR,
    DONE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT_ADDR   = 16'h2004;
  localparam int unsigned OAM_BYTES            = 256;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA: a CPU write to TRIGGER_ADDR halts the CPU and copies page
// {cpu_wdata,00..FF} from synchronous RAM to OAM_DATA_ADDR, 3 clocks per byte.
// Optional build macro OAM_DMA_ALIGN_EN: an odd CPU cycle seen in HALT adds
// one ALIGN cycle before the first read.
module oam_dma_controller
  import nes_dma_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH    = 8,
  parameter int unsigned                ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]   TRIGGER_ADDR  = OAM_DMA_TRIGGER_ADDR,
  parameter logic [ADDRESS_WIDTH-1:0]   OAM_DATA_ADDR = OAM_DATA_PORT_ADDR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_enable,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic                     cpu_odd_cycle,
  output logic                     dma_active,
  output logic                     dma_done,
  output logic                     bus_enable,
  output logic                     bus_we,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0]    bus_data
);

  localparam logic [7:0] LastIndex = 8'(OAM_BYTES - 1);

  dma_state_t            state_q, state_d;
  logic [7:0]            index_q, index_d;
  logic [DATA_WIDTH-1:0] page_q, page_d;
  logic [DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic                  trigger;

  assign trigger = cpu_enable && cpu_we && (cpu_address == TRIGGER_ADDR);

`ifndef OAM_DMA_ALIGN_EN
  logic unused_odd_cycle;
  assign unused_odd_cycle = cpu_odd_cycle;
`endif

  // Only the WR state owns the shared data bus.
  assign bus_data = (state_q == WR) ? buffer_q : {DATA_WIDTH{1'bz}};

  // State, byte index, page and read buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      page_q   <= '0;
      buffer_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      page_q   <= page_d;
      buffer_q <= buffer_d;
    end
  end

  // Next-state sequencing and per-state bus controls.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    page_d      = page_q;
    buffer_d    = buffer_q;
    dma_active  = 1'b0;
    dma_done    = 1'b0;
    bus_enable  = 1'b0;
    bus_we      = 1'b0;
    bus_address = '0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = cpu_wdata;
          state_d = HALT;
        end
      end
      HALT: begin
        dma_active = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
        state_d = cpu_odd_cycle ? ALIGN : RD_ADDR;
`else
        state_d = RD_ADDR;
`endif
      end
      ALIGN: begin
        dma_active = 1'b1;
        state_d    = RD_ADDR;
      end
      RD_ADDR: begin
        dma_active  = 1'b1;
        bus_enable  = 1'b1;
        bus_address = ADDRESS_WIDTH'({page_q, index_q});
        state_d     = RD_DATA;
      end
      RD_DATA: begin
        dma_active  = 1'b1;
        bus_enable  = 1'b1;
        bus_address = ADDRESS_WIDTH'({page_q, index_q});
        buffer_d    = bus_data;
        state_d     = WR;
      end
      WR: begin
        dma_active  = 1'b1;
        bus_enable  = 1'b1;
        bus_we      = 1'b1;
        bus_address = OAM_DATA_ADDR;
        // The increment wraps 255 -> 0, leaving index ready for the next transfer.
        index_d     = index_q + 8'd1;
        state_d     = (index_q == LastIndex) ? DONE : RD_ADDR;
      end
      DONE: begin
        dma_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: synchronous RAM model, a
// cycle-count transfer model, and directed scenarios with literal checks.
module tb_oam_dma_controller;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_enable = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_odd_cycle = 1'b0;
  logic        dma_active, dma_done, bus_enable, bus_we;
  logic [15:0] bus_address;
  wire  [7:0]  bus_data;

  int tests = 0;
  int fails = 0;

  oam_dma_controller dut (
    .clk(clk), .rst_n(rst_n), .cpu_enable(cpu_enable), .cpu_we(cpu_we),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_odd_cycle(cpu_odd_cycle),
    .dma_active(dma_active), .dma_done(dma_done), .bus_enable(bus_enable),
    .bus_we(bus_we), .bus_address(bus_address), .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  // RAM contents: page 02 holds i^A5, other pages a distinct pattern.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Synchronous RAM: registers a read at the edge, drives the bus next cycle.
  logic [7:0] mem [0:65535];
  logic [7:0] ram_q = 8'h00;
  logic       ram_oe = 1'b0;
  initial for (int a = 0; a < 65536; a++) mem[a] = src_byte(16'(a));
  always @(posedge clk) begin
    if (bus_enable && !bus_we) ram_q <= mem[bus_address];
    ram_oe <= bus_enable && !bus_we;
  end
  assign bus_data = (ram_oe && !bus_we) ? ram_q : 8'bz;

  // Transfer model: k counts clocks since the trigger edge (0 = idle).
  int         k = 0;
  logic [7:0] m_page = 8'h00;
  bit         m_align = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; m_page <= 8'h00; m_align <= 1'b0;
    end else if (k == 0) begin
      if (cpu_enable && cpu_we && cpu_address == 16'h4014) begin
        k <= 1; m_page <= cpu_wdata; m_align <= 1'b0;
      end
    end else begin
      if (k == 1) m_align <= AlignOn && cpu_odd_cycle;
      if (k == 770 + int'(m_align)) k <= 0;
      else k <= k + 1;
    end
  end

  // Observed totals, written only here.
  logic [7:0]  oam[$];
  int          act_total = 0, done_total = 0, zero_reads = 0, page3_reads = 0;
  logic [15:0] last_read = 16'h0000;

  // Per-cycle compare against the model plus statistics collection.
  always @(negedge clk) begin
    automatic logic e_act = 0, e_done = 0, e_en = 0, e_we = 0, chk_d = 0;
    automatic logic [15:0] e_addr = 16'h0000;
    automatic logic [7:0]  e_data = 8'h00;
    automatic int first = 2 + int'(m_align);
    automatic int last = 769 + int'(m_align);
    if (k != 0) begin
      if (k < first) e_act = 1;
      else if (k <= last) begin
        automatic int j = k - first;
        automatic int b = j / 3;
        e_act = 1; e_en = 1;
        if (j % 3 == 2) begin
          e_we = 1; e_addr = 16'h2004; chk_d = 1;
          e_data = src_byte({m_page, 8'(b)});
        end else e_addr = {m_page, 8'(b)};
      end else e_done = 1;
    end
    tests++;
    if (dma_active !== e_act || dma_done !== e_done || bus_enable !== e_en ||
        bus_we !== e_we || bus_address !== e_addr || (chk_d && bus_data !== e_data)) begin
      fails++;
      $display("FAIL cycle t=%0t k=%0d: act/done/en/we/addr/data got %b%b%b%b %h %h exp %b%b%b%b %h %h",
               $time, k, dma_active, dma_done, bus_enable, bus_we, bus_address, bus_data,
               e_act, e_done, e_en, e_we, e_addr, e_data);
    end
    if (dma_active) act_total++;
    if (dma_done) done_total++;
    if (bus_enable && bus_we && bus_address == 16'h2004) oam.push_back(bus_data);
    if (bus_enable && !bus_we) begin
      last_read = bus_address;
      if (bus_address == 16'h0000) zero_reads++;
      if (bus_address[15:8] == 8'h03) page3_reads++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic en,
                           input logic we);
    @(posedge clk); #1;
    cpu_enable = en; cpu_we = we; cpu_address = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_enable = 0; cpu_we = 0; cpu_address = 16'h0000;
  endtask

  task automatic wait_done(input int done_base);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (done_total > done_base) break;
    end
    check("done_within_budget", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_writes(input int target);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (oam.size() >= target) break;
    end
    check("writes_within_budget", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int ob, ab, db, zb, pb, bad;
    // Reset state.
    #12;
    check("reset_active", 32'(dma_active), 32'd0);
    check("reset_bus", {bus_enable, bus_we, dma_done, bus_address}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full transfer of page 02.
    ob = oam.size(); ab = act_total; db = done_total;
    cpu_cycle(16'h4014, 8'h02, 1, 1);
    wait_done(db);
    check("full_count", oam.size() - ob, 256);
    check("full_first", oam[ob], 8'hA5);
    check("full_second", oam[ob + 1], 8'hA4);
    check("full_last", oam[ob + 255], 8'h5A);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[ob + i] !== (8'(i) ^ 8'hA5)) bad++;
    check("full_order", bad, 0);
    check("full_active", act_total - ab, 769);
    check("full_done", done_total - db, 1);

    // Retrigger during byte 10 is ignored.
    ob = oam.size(); ab = act_total; db = done_total; pb = page3_reads;
    cpu_cycle(16'h4014, 8'h02, 1, 1);
    wait_writes(ob + 10);
    cpu_cycle(16'h4014, 8'h03, 1, 1);
    wait_done(db);
    check("retrig_count", oam.size() - ob, 256);
    check("retrig_page3", page3_reads - pb, 0);
    check("retrig_active", act_total - ab, 769);

    // Top page: ends at $FFFF without wrapping to $0000.
    ob = oam.size(); db = done_total; zb = zero_reads;
    cpu_cycle(16'h4014, 8'hFF, 1, 1);
    wait_done(db);
    check("top_last_read", last_read, 16'hFFFF);
    check("top_zero_reads", zero_reads - zb, 0);
    check("top_last_byte", oam[ob + 255], 8'h3C);
    check("top_count", oam.size() - ob, 256);

    // Asynchronous reset during byte 100.
    ob = oam.size(); db = done_total;
    cpu_cycle(16'h4014, 8'h02, 1, 1);
    wait_writes(ob + 100);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_mid_active", 32'(dma_active), 32'd0);
    check("rst_mid_bus", {bus_enable, bus_we, bus_address}, 32'd0);
    repeat (3) @(posedge clk);
    check("rst_mid_no_done", done_total - db, 0);
    @(negedge clk); rst_n = 1'b1;
    ob = oam.size(); db = done_total;
    cpu_cycle(16'h4014, 8'h02, 1, 1);
    wait_done(db);
    check("restart_first", oam[ob], 8'hA5);
    check("restart_count", oam.size() - ob, 256);

    // Non-triggers.
    ab = act_total;
    cpu_cycle(16'h4015, 8'h02, 1, 1);
    cpu_cycle(16'h4014, 8'h02, 1, 0);
    cpu_cycle(16'h4014, 8'h02, 0, 1);
    repeat (5) @(posedge clk);
    check("non_trigger_active", act_total - ab, 0);

    // Alignment with an odd CPU cycle in HALT.
    ab = act_total; db = done_total;
    cpu_odd_cycle = 1'b1;
    cpu_cycle(16'h4014, 8'h02, 1, 1);
    wait_done(db);
    cpu_odd_cycle = 1'b0;
    check("odd_active", act_total - ab, 769 + int'(AlignOn));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sprite DMA engine for the NES CPU bus. It snoops CPU writes to $4014 and halts the CPU. It then copies the 256-byte page $XX00-$XXFF out of the synchronous system RAM into the PPU OAM data port ($2004), one byte at a time. It sits directly upstream of the RAM. When dma_active is high, the top-level bus mux hands RAM enable/WE/address to this block.

Parameters:
DATA_WIDTH, 8, bus data width; must be 8.
ADDRESS_WIDTH, 16, bus address width.
TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
OAM_DATA_ADDR, 16'h2004, destination address for every write.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
cpu_enable  input  1  CPU bus cycle valid.
cpu_we  input  1  CPU write strobe.
cpu_address  input  ADDRESS_WIDTH  CPU bus address.
cpu_wdata  input  DATA_WIDTH  CPU write data; page number on trigger.
cpu_odd_cycle  input  1  high on odd CPU cycles; used only with the optional feature.
dma_active  output  1  CPU halt and bus-mux select.
dma_done  output  1  one-cycle completion pulse.
bus_enable  output  1  RAM enable.
bus_we  output  1  RAM write enable.
bus_address  output  ADDRESS_WIDTH  RAM address.
bus_data  inout  DATA_WIDTH  shared RAM data bus.

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, index 0, page 0.
  - All outputs 0; bus_data released to Z.
  - Applies immediately, including mid-transfer; no partial completion and no dma_done.
- Trigger: sampled in IDLE only, at a rising edge where cpu_enable && cpu_we && cpu_address==TRIGGER_ADDR.
  - On that edge, page <= cpu_wdata and state -> HALT.
  - Triggers outside IDLE are ignored.
- States and outputs:
  - IDLE: everything low.
  - HALT: dma_active=1, bus_enable=0; one dummy cycle, then RD_ADDR.
  - RD_ADDR: bus_enable=1, bus_we=0, bus_address={page,index}. The RAM registers its output at the edge closing this cycle.
  - RD_DATA: same address and controls held; RAM drives bus_data; buffer <= bus_data at the closing edge.
  - WR: bus_enable=1, bus_we=1, bus_address=OAM_DATA_ADDR, bus_data driven with buffer.
    - If index==255, go to DONE; otherwise index <= index+1 and go to RD_ADDR.
  - DONE: dma_active=0, dma_done=1 for exactly one cycle, then IDLE.
- bus_data is driven only in WR; it is Z in every other state.
- Source address is zero-extended {page,index}. index is 8 bits, and the 255->0 wrap ends the transfer.
- Timing:
  - 3 clocks per byte.
  - dma_active high for 1+768 = 769 clocks, starting the cycle after the trigger edge.
  - dma_done in clock 770.
- Byte order: OAM receives bytes in source order $XX00 first.

Optional Feature:
OAM_DMA_ALIGN_EN:
- Defined: in HALT, if cpu_odd_cycle==1, insert one extra ALIGN state before RD_ADDR. ALIGN has the same outputs as HALT, giving 770 active clocks.
- Undefined: no ALIGN state; cpu_odd_cycle is ignored; always 769 clocks.

Decomposition:
- Package nes_dma_pkg holds:
  - typedef enum dma_state_t {IDLE, HALT, ALIGN, RD_ADDR, RD_DATA, WR, DONE};
  - default constants OAM_DMA_TRIGGER_ADDR=16'h4014, OAM_DATA_PORT_ADDR=16'h2004, OAM_BYTES=256.
- Single module, no sub-module; the tri-state driver is one continuous assign gated by state==WR.

Test Plan:
- Full transfer:
  - Stimulus: RAM $0200-$02FF = i^8'hA5; write 8'h02 to $4014.
  - Response: exactly 256 WR cycles at $2004 carrying A5,A4,...,5A in order; dma_active=769 clocks; one dma_done pulse; bus_data Z outside WR.
- Retrigger: write 8'h03 to $4014 at byte 10 -> ignored; all source addresses stay $02xx; count unchanged.
- Top page: trigger page 8'hFF -> last read at $FFFF, then DONE; no read at $0000.
- Reset mid-transfer:
  - Stimulus: rst_n low asynchronously during byte 100.
  - Response: dma_active, bus_* drop immediately and bus_data goes Z; no dma_done; a new trigger restarts at index 0.
- Non-triggers: write to $4015, read of $4014, write with cpu_enable=0 -> dma_active stays 0.
- Alignment: with OAM_DMA_ALIGN_EN, cpu_odd_cycle=1 in HALT -> 770 active clocks, cpu_odd_cycle=0 -> 769; without the macro -> 769 regardless.
